// File: rtl/retire_stage_pkg.sv
// Shared types and constants for the retire stage and its head-window selector.
package retire_stage_pkg;

  localparam int unsigned RETIRE_WIDTH = 3;
  localparam int unsigned PREG_W       = 6;
  localparam int unsigned AREG_W       = 5;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned CNT_W        = $clog2(RETIRE_WIDTH + 1);
  localparam int unsigned RCOUNT_W     = 64;

  // One ROB entry as seen by the retire stage.
  typedef struct packed {
    logic              valid;
    logic              completed;
    logic [XLEN-1:0]   PC;
    logic [PREG_W-1:0] Tnew;
    logic [PREG_W-1:0] Told;
    logic [AREG_W-1:0] arch_dest;
    logic              is_store;
    logic              halt;
    logic              precise_state_need;
    logic [XLEN-1:0]   cs_retire_pc;
  } ROB_ENTRY_PACKET;

  typedef enum logic [1:0] {
    RS_NORMAL = 2'd0,
    RS_SQUASH = 2'd1,
    RS_DRAIN  = 2'd2,
    RS_HALTED = 2'd3
  } retire_state_e;

  // Why the retire group ended where it did this cycle.
  typedef enum logic [2:0] {
    TR_NONE     = 3'd0,
    TR_IDLE     = 3'd1,
    TR_NOT_DONE = 3'd2,
    TR_STORE    = 3'd3,
    TR_SQUASH   = 3'd4,
    TR_HALT     = 3'd5
  } trunc_e;

endpackage

// File: rtl/retire_stage_select.sv
// Combinational in-order prefix selection over the ROB head window.
module retire_select
  import retire_stage_pkg::*;
(
  input  logic                               i_enable,
  input  logic                               i_sq_ready,
  input  ROB_ENTRY_PACKET [RETIRE_WIDTH-1:0] i_entry,
  output logic [RETIRE_WIDTH-1:0]            o_mask_c,
  output logic [CNT_W-1:0]                   o_cnt_c,
  output trunc_e                             o_reason_c,
  output logic [XLEN-1:0]                    o_redirect_pc_c
);

  logic w_open;
  logic w_store_seen;
  logic w_unused_fields;

  // Walk oldest to youngest; the first slot that cannot retire closes the group.
  always_comb begin
    o_mask_c        = '0;
    o_cnt_c         = '0;
    o_reason_c      = i_enable ? TR_NONE : TR_IDLE;
    o_redirect_pc_c = '0;
    w_open          = i_enable;
    w_store_seen    = 1'b0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      if (w_open) begin
        if (!(i_entry[i].valid && i_entry[i].completed)) begin
          w_open     = 1'b0;
          o_reason_c = TR_NOT_DONE;
        end else if (i_entry[i].is_store && (w_store_seen || !i_sq_ready)) begin
          // Only one store may leave per cycle, and only when the SQ accepts it.
          w_open     = 1'b0;
          o_reason_c = TR_STORE;
        end else begin
          o_mask_c[i] = 1'b1;
          o_cnt_c     = CNT_W'(i + 1);
          if (i_entry[i].is_store) begin
            w_store_seen = 1'b1;
          end
          // Halt takes priority over a redirect on the same entry.
          if (i_entry[i].halt) begin
            w_open     = 1'b0;
            o_reason_c = TR_HALT;
          end else if (i_entry[i].precise_state_need) begin
            w_open          = 1'b0;
            o_reason_c      = TR_SQUASH;
            o_redirect_pc_c = i_entry[i].cs_retire_pc;
          end
        end
      end
    end
  end

  // Payload fields are consumed by the parent, not by the selector.
  always_comb begin
    w_unused_fields = 1'b0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      w_unused_fields = w_unused_fields ^ (^{i_entry[i].PC, i_entry[i].Tnew,
                                             i_entry[i].Told, i_entry[i].arch_dest});
    end
  end

endmodule

// File: rtl/retire_stage.sv
// Retire stage: commits up to RETIRE_WIDTH head entries per cycle and drives
// freelist, map table, store queue and fetch-redirect updates.
module retire_stage
  import retire_stage_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  ROB_ENTRY_PACKET [RETIRE_WIDTH-1:0]    rob_head_entry,
  input  logic                                  sq_retire_ready,
  output logic [CNT_W-1:0]                      rs_retire_cnt,
  output logic [RETIRE_WIDTH-1:0]               fl_release_valid,
  output logic [RETIRE_WIDTH-1:0][PREG_W-1:0]   fl_release_preg,
  output logic [RETIRE_WIDTH-1:0]               amt_wr_valid,
  output logic [RETIRE_WIDTH-1:0][AREG_W-1:0]   amt_wr_areg,
  output logic [RETIRE_WIDTH-1:0][PREG_W-1:0]   amt_wr_preg,
  output logic                                  sq_retire_valid,
  output logic                                  fch_rec_enable,
  output logic [XLEN-1:0]                       fch_rec_pc,
  output logic                                  halted,
  output logic [RCOUNT_W-1:0]                   retired_count
);

  retire_state_e r_state;
  retire_state_e w_state_nxt;

  logic                                w_sel_enable;
  logic [RETIRE_WIDTH-1:0]             w_sel_mask;
  logic [CNT_W-1:0]                    w_sel_cnt;
  trunc_e                              w_sel_reason;
  logic [XLEN-1:0]                     w_sel_redirect_pc;

  logic                                w_rec_en_nxt;
  logic [XLEN-1:0]                     w_rec_pc_nxt;
  logic                                w_halted_nxt;

  logic [RETIRE_WIDTH-1:0]             w_fl_valid_nxt;
  logic [RETIRE_WIDTH-1:0][PREG_W-1:0] w_fl_preg_nxt;
  logic [RETIRE_WIDTH-1:0]             w_amt_valid_nxt;
  logic [RETIRE_WIDTH-1:0][AREG_W-1:0] w_amt_areg_nxt;
  logic [RETIRE_WIDTH-1:0][PREG_W-1:0] w_amt_preg_nxt;
  logic                                w_sq_valid_nxt;

  // Retirement is only open in NORMAL and never while reset is held.
  assign w_sel_enable  = rst_n && (r_state == RS_NORMAL);
  assign rs_retire_cnt = w_sel_cnt;

  retire_select u_select (
    .i_enable        (w_sel_enable),
    .i_sq_ready      (sq_retire_ready),
    .i_entry         (rob_head_entry),
    .o_mask_c        (w_sel_mask),
    .o_cnt_c         (w_sel_cnt),
    .o_reason_c      (w_sel_reason),
    .o_redirect_pc_c (w_sel_redirect_pc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RS_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus redirect/halt flags for the output registers.
  always_comb begin
    w_state_nxt  = r_state;
    w_rec_en_nxt = 1'b0;
    w_rec_pc_nxt = '0;
    w_halted_nxt = 1'b0;
    case (r_state)
      RS_NORMAL: begin
        if (w_sel_reason == TR_HALT) begin
          w_state_nxt  = RS_HALTED;
          w_halted_nxt = 1'b1;
        end else if (w_sel_reason == TR_SQUASH) begin
          w_state_nxt  = RS_SQUASH;
          w_rec_en_nxt = 1'b1;
          w_rec_pc_nxt = w_sel_redirect_pc;
        end
      end
      RS_SQUASH: w_state_nxt = RS_DRAIN;
      RS_DRAIN:  w_state_nxt = RS_NORMAL;
      RS_HALTED: begin
        w_state_nxt  = RS_HALTED;
        w_halted_nxt = 1'b1;
      end
      default:   w_state_nxt = RS_NORMAL;
    endcase
  end

  // Per-slot freelist/map/store updates for the retiring prefix; x0 writes nothing.
  always_comb begin
    w_fl_valid_nxt  = '0;
    w_fl_preg_nxt   = '0;
    w_amt_valid_nxt = '0;
    w_amt_areg_nxt  = '0;
    w_amt_preg_nxt  = '0;
    w_sq_valid_nxt  = 1'b0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      if (w_sel_mask[i]) begin
        if (rob_head_entry[i].arch_dest != '0) begin
          w_fl_valid_nxt[i]  = 1'b1;
          w_fl_preg_nxt[i]   = rob_head_entry[i].Told;
          w_amt_valid_nxt[i] = 1'b1;
          w_amt_areg_nxt[i]  = rob_head_entry[i].arch_dest;
          w_amt_preg_nxt[i]  = rob_head_entry[i].Tnew;
        end
        if (rob_head_entry[i].is_store) begin
          w_sq_valid_nxt = 1'b1;
        end
      end
    end
  end

  // Registered commit strobes, redirect pulse, halt flag and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_release_valid <= '0;
      fl_release_preg  <= '0;
      amt_wr_valid     <= '0;
      amt_wr_areg      <= '0;
      amt_wr_preg      <= '0;
      sq_retire_valid  <= 1'b0;
      fch_rec_enable   <= 1'b0;
      fch_rec_pc       <= '0;
      halted           <= 1'b0;
      retired_count    <= '0;
    end else begin
      fl_release_valid <= w_fl_valid_nxt;
      fl_release_preg  <= w_fl_preg_nxt;
      amt_wr_valid     <= w_amt_valid_nxt;
      amt_wr_areg      <= w_amt_areg_nxt;
      amt_wr_preg      <= w_amt_preg_nxt;
      sq_retire_valid  <= w_sq_valid_nxt;
      fch_rec_enable   <= w_rec_en_nxt;
      fch_rec_pc       <= w_rec_pc_nxt;
      halted           <= w_halted_nxt;
      retired_count    <= retired_count + RCOUNT_W'(w_sel_cnt);
    end
  end

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: stimulus pushes per-cycle expectations
// from a behavioural model, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_retire_stage;
  import retire_stage_pkg::*;

  typedef ROB_ENTRY_PACKET [RETIRE_WIDTH-1:0] win_t;

  typedef struct {
    int unsigned                          cnt;
    logic [RETIRE_WIDTH-1:0]              flv;
    logic [RETIRE_WIDTH-1:0][PREG_W-1:0]  flp;
    logic [RETIRE_WIDTH-1:0]              amv;
    logic [RETIRE_WIDTH-1:0][AREG_W-1:0]  ama;
    logic [RETIRE_WIDTH-1:0][PREG_W-1:0]  amp;
    logic                                 sqv;
    logic                                 fen;
    logic [XLEN-1:0]                      fpc;
    logic                                 hlt;
    logic [63:0]                          rc;
  } exp_t;

  logic                                  clk = 1'b0;
  logic                                  rst_n;
  win_t                                  rob_head_entry;
  logic                                  sq_retire_ready;
  logic [CNT_W-1:0]                      rs_retire_cnt;
  logic [RETIRE_WIDTH-1:0]               fl_release_valid;
  logic [RETIRE_WIDTH-1:0][PREG_W-1:0]   fl_release_preg;
  logic [RETIRE_WIDTH-1:0]               amt_wr_valid;
  logic [RETIRE_WIDTH-1:0][AREG_W-1:0]   amt_wr_areg;
  logic [RETIRE_WIDTH-1:0][PREG_W-1:0]   amt_wr_preg;
  logic                                  sq_retire_valid;
  logic                                  fch_rec_enable;
  logic [XLEN-1:0]                       fch_rec_pc;
  logic                                  halted;
  logic [63:0]                           retired_count;

  always #5 clk = ~clk;

  retire_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rob_head_entry   (rob_head_entry),
    .sq_retire_ready  (sq_retire_ready),
    .rs_retire_cnt    (rs_retire_cnt),
    .fl_release_valid (fl_release_valid),
    .fl_release_preg  (fl_release_preg),
    .amt_wr_valid     (amt_wr_valid),
    .amt_wr_areg      (amt_wr_areg),
    .amt_wr_preg      (amt_wr_preg),
    .sq_retire_valid  (sq_retire_valid),
    .fch_rec_enable   (fch_rec_enable),
    .fch_rec_pc       (fch_rec_pc),
    .halted           (halted),
    .retired_count    (retired_count)
  );

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;

  // Model state: bubbles left after a redirect, sticky halt, running retire sum,
  // and the registered outputs the DUT should show next cycle.
  int          m_stall;
  bit          m_halted;
  longint unsigned m_sum;
  exp_t        m_pend;

  function automatic exp_t zexp();
    exp_t z;
    z.cnt = 0; z.flv = '0; z.flp = '0; z.amv = '0; z.ama = '0; z.amp = '0;
    z.sqv = 1'b0; z.fen = 1'b0; z.fpc = '0; z.hlt = 1'b0; z.rc = '0;
    return z;
  endfunction

  function automatic ROB_ENTRY_PACKET mk(input logic [31:0] pc, input int told, input int tnew,
                                         input int arch, input bit comp, input bit st,
                                         input bit hl, input bit psn, input logic [31:0] cspc);
    ROB_ENTRY_PACKET e;
    e.valid = 1'b1; e.completed = comp; e.PC = pc;
    e.Told = PREG_W'(told); e.Tnew = PREG_W'(tnew); e.arch_dest = AREG_W'(arch);
    e.is_store = st; e.halt = hl; e.precise_state_need = psn; e.cs_retire_pc = cspc;
    return e;
  endfunction

  function automatic ROB_ENTRY_PACKET rnd_entry(input int unsigned halt_pct);
    ROB_ENTRY_PACKET e;
    e.valid              = ($urandom_range(0, 99) < 85);
    e.completed          = ($urandom_range(0, 99) < 75);
    e.PC                 = $urandom;
    e.Tnew               = PREG_W'($urandom);
    e.Told               = PREG_W'($urandom);
    e.arch_dest          = ($urandom_range(0, 7) == 0) ? '0 : AREG_W'($urandom_range(1, 31));
    e.is_store           = ($urandom_range(0, 99) < 25);
    e.halt               = ($urandom_range(0, 99) < halt_pct);
    e.precise_state_need = ($urandom_range(0, 99) < 8);
    e.cs_retire_pc       = $urandom;
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show this cycle.
  task automatic step(input win_t win, input bit rdy, input bit rst);
    exp_t e;
    int n, stores;
    bit hit_halt, hit_psn;
    logic [31:0] pc;
    @(posedge clk);
    #1;
    rob_head_entry  = win;
    sq_retire_ready = rdy;
    rst_n           = rst;
    n = 0; stores = 0; hit_halt = 0; hit_psn = 0; pc = '0;
    if (!rst) begin
      q.push_back(zexp());
      m_stall = 0; m_halted = 0; m_sum = 0; m_pend = zexp();
    end else begin
      if (m_stall > 0) begin
        m_stall--;
      end else if (!m_halted) begin
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
          if (!win[i].valid || !win[i].completed) break;
          if (win[i].is_store) begin
            if (stores != 0 || !rdy) break;
            stores++;
          end
          n++;
          if (win[i].halt) begin hit_halt = 1; break; end
          if (win[i].precise_state_need) begin hit_psn = 1; pc = win[i].cs_retire_pc; break; end
        end
      end
      e     = m_pend;
      e.cnt = n;
      e.rc  = m_sum;
      q.push_back(e);
      m_pend = zexp();
      for (int i = 0; i < n; i++) begin
        if (win[i].arch_dest != 0) begin
          m_pend.flv[i] = 1'b1; m_pend.flp[i] = win[i].Told;
          m_pend.amv[i] = 1'b1; m_pend.ama[i] = win[i].arch_dest; m_pend.amp[i] = win[i].Tnew;
        end
      end
      m_pend.sqv = (stores > 0);
      if (hit_halt) m_halted = 1;
      else if (hit_psn) begin
        m_stall    = 2;
        m_pend.fen = 1'b1;
        m_pend.fpc = pc;
      end
      m_pend.hlt = m_halted;
      m_sum += longint'(n);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rs_retire_cnt", 64'(rs_retire_cnt), 64'(e.cnt));
        chk("fl_release_valid", 64'(fl_release_valid), 64'(e.flv));
        chk("amt_wr_valid", 64'(amt_wr_valid), 64'(e.amv));
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
          if (e.flv[i]) chk("fl_release_preg", 64'(fl_release_preg[i]), 64'(e.flp[i]));
          if (e.amv[i]) begin
            chk("amt_wr_areg", 64'(amt_wr_areg[i]), 64'(e.ama[i]));
            chk("amt_wr_preg", 64'(amt_wr_preg[i]), 64'(e.amp[i]));
          end
        end
        chk("sq_retire_valid", 64'(sq_retire_valid), 64'(e.sqv));
        chk("fch_rec_enable", 64'(fch_rec_enable), 64'(e.fen));
        if (e.fen) chk("fch_rec_pc", 64'(fch_rec_pc), 64'(e.fpc));
        chk("halted", 64'(halted), 64'(e.hlt));
        chk("retired_count", retired_count, e.rc);
      end
    end
  end

  initial begin : stim
    win_t idle, w;
    idle = '0;
    rob_head_entry = '0; sq_retire_ready = 1'b0; rst_n = 1'b0;
    m_stall = 0; m_halted = 0; m_sum = 0; m_pend = zexp();
    repeat (2) @(posedge clk);
    step(idle, 1'b1, 1'b0);

    // Full three-wide retire, then observe the strobes.
    w[0] = mk(32'h1000, 1, 4, 1, 1, 0, 0, 0, 0);
    w[1] = mk(32'h1004, 2, 5, 2, 1, 0, 0, 0, 0);
    w[2] = mk(32'h1008, 3, 6, 3, 1, 0, 0, 0, 0);
    step(w, 1'b1, 1'b1);
    step(idle, 1'b1, 1'b1);

    // Gap at slot 1.
    w[1].completed = 1'b0;
    step(w, 1'b1, 1'b1);
    step(idle, 1'b1, 1'b1);

    // Two stores: one per cycle, and none when the SQ is not ready.
    w[0] = mk(32'h2000, 7, 8, 4, 1, 1, 0, 0, 0);
    w[1] = mk(32'h2004, 9, 10, 5, 1, 1, 0, 0, 0);
    w[2] = mk(32'h2008, 11, 12, 0, 1, 0, 0, 0, 0);
    step(w, 1'b1, 1'b1);
    step(w, 1'b0, 1'b1);
    step(idle, 1'b1, 1'b1);

    // Mispredict: redirect, drain, then normal retire again.
    w[0] = mk(32'h4000, 13, 14, 6, 1, 0, 0, 1, 32'h5000);
    w[1] = mk(32'h4004, 15, 16, 7, 1, 0, 0, 0, 0);
    w[2] = mk(32'h4008, 17, 18, 8, 1, 0, 0, 0, 0);
    step(w, 1'b1, 1'b1);
    w[0].precise_state_need = 1'b0;
    repeat (3) step(w, 1'b1, 1'b1);

    // Randomized traffic without halts.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < RETIRE_WIDTH; i++) w[i] = rnd_entry(0);
      step(w, ($urandom_range(0, 3) != 0), 1'b1);
    end
    step(idle, 1'b1, 1'b1);

    // Reset asserted while the redirect pulse is up, then resume.
    w[0] = mk(32'h6000, 20, 21, 9, 1, 0, 0, 1, 32'h7000);
    w[1] = mk(32'h6004, 22, 23, 10, 1, 0, 0, 0, 0);
    w[2] = mk(32'h6008, 24, 25, 11, 1, 0, 0, 0, 0);
    step(w, 1'b1, 1'b1);
    w[0].precise_state_need = 1'b0;
    step(w, 1'b1, 1'b0);
    step(w, 1'b1, 1'b1);
    step(idle, 1'b1, 1'b1);

    // Halt at slot 1 (also a mispredict: halt wins), then nothing retires.
    w[0] = mk(32'h8000, 26, 27, 12, 1, 0, 0, 0, 0);
    w[1] = mk(32'h8004, 28, 29, 13, 1, 0, 1, 1, 32'h9000);
    w[2] = mk(32'h8008, 30, 31, 14, 1, 0, 0, 0, 0);
    step(w, 1'b1, 1'b1);
    w[1].halt = 1'b0; w[1].precise_state_need = 1'b0;
    repeat (3) step(w, 1'b1, 1'b1);

    // Leave halt through reset, then random traffic with rare halts.
    step(idle, 1'b1, 1'b0);
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < RETIRE_WIDTH; i++) w[i] = rnd_entry(2);
      step(w, ($urandom_range(0, 3) != 0), 1'b1);
    end
    step(idle, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
